// File: rtl/imm_gen_pkg.sv
// Shared format codes and the held-entry layout for the immediate generator.
package imm_gen_pkg;

  localparam logic [2:0] EXT_OP_NONE  = 3'b000;
  localparam logic [2:0] EXT_OP_S     = 3'b001;
  localparam logic [2:0] EXT_OP_I     = 3'b010;
  localparam logic [2:0] EXT_OP_B     = 3'b011;
  localparam logic [2:0] EXT_OP_U     = 3'b100;
  localparam logic [2:0] EXT_OP_J     = 3'b101;
  localparam logic [2:0] EXT_OP_SHAMT = 3'b110;
  localparam logic [2:0] EXT_OP_ZIMM  = 3'b111;

  // Entries are sized for the widest legal configuration; narrower
  // instances leave the upper bits at zero and synthesis trims them.
  localparam int IMM_W_MAX = 64;
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [IMM_W_MAX-1:0] imm;
    logic [TAG_W_MAX-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extraction and extension for all RV base formats.
module imm_ext
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      ext_op,
  output logic [XLEN-1:0] imm
);

  // Opcode bits never feed an immediate.
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  // Signed size casts replicate the field MSB up to XLEN.
  always_comb begin
    imm = '0;
    case (ext_op)
      EXT_OP_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      EXT_OP_I:     imm = XLEN'($signed(instr[31:20]));
      EXT_OP_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
      EXT_OP_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      EXT_OP_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
      EXT_OP_SHAMT: imm = XLEN'(instr[20 +: SHAMT_W]);
      EXT_OP_ZIMM:  imm = XLEN'(instr[19:15]);
      default:      imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extension ahead of a main register plus a
// one-entry skid, so in_ready is registered and never waits on out_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] ext_imm;
  imm_entry_t      in_ent, main_q, skid_q;
  logic            main_vld, skid_vld;
  logic            fire_in, main_free;

  imm_ext #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_ext (
    .instr  (instr),
    .ext_op (ext_op),
    .imm    (ext_imm)
  );

  // Pack the extended immediate and tag into a zero-padded entry.
  always_comb begin
    in_ent = '0;
    in_ent.imm[XLEN-1:0] = ext_imm;
    in_ent.tag[TAG_W-1:0] = in_tag;
  end

  // The skid only fills while main is stalled, so an occupied skid is the
  // only condition that refuses input.
  assign in_ready  = ~skid_vld;
  assign fire_in   = in_valid & in_ready;
  assign main_free = ~main_vld | out_ready;

  // Main/skid update: reset clears everything, flush drops valids only.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_q   <= in_ent;
        main_vld <= fire_in;
      end
    end else if (fire_in) begin
      skid_q   <= in_ent;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid = main_vld;
  assign out_imm   = main_q.imm[XLEN-1:0];
  assign out_tag   = main_q.tag[TAG_W-1:0];

  // Padding bits above XLEN/TAG_W are held at zero and intentionally unread.
  logic unused_pad;
  assign unused_pad = ^{main_q, skid_q};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared inputs,
// checked every cycle against a FIFO model plus literal expectations.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  ext_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag32, out_tag64;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .instr(instr), .ext_op(ext_op), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(6), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .instr(instr), .ext_op(ext_op), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpret a w-bit field as a two's-complement integer.
  function automatic longint sx(input longint f, input int w);
    if (((f >> (w - 1)) & 1) != 0) return f - (longint'(1) << w);
    return f;
  endfunction

  // Reference immediate straight from the format rules, masked to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] op,
                                          input int xlen);
    longint v;
    case (op)
      3'd1: v = sx(longint'({i[31:25], i[11:7]}), 12);
      3'd2: v = sx(longint'(i[31:20]), 12);
      3'd3: v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      3'd4: v = sx(longint'({i[31:12], 12'b0}), 32);
      3'd5: v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      3'd6: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd7: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // Model: an ordered queue of accepted ops holding at most two.
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  op;
    logic [4:0]  tag;
  } ent_t;
  ent_t q[$];
  int   msz;
  bit   mfire;

  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else begin
      msz   = q.size();
      mfire = in_valid && (msz < 2);
      if (msz > 0 && out_ready) void'(q.pop_front());
      if (mfire) q.push_back('{instr, ext_op, in_tag});
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid32", out_valid32, q.size() > 0);
      chk("out_valid64", out_valid64, q.size() > 0);
      chk("in_ready32", in_ready32, q.size() < 2);
      chk("in_ready64", in_ready64, q.size() < 2);
      if (q.size() > 0) begin
        chk("imm32", {32'b0, out_imm32}, ref_imm(q[0].instr, q[0].op, 32));
        chk("imm64", out_imm64, ref_imm(q[0].instr, q[0].op, 64));
        chk("tag32", out_tag32, q[0].tag);
        chk("tag64", out_tag64, q[0].tag);
      end
    end
  end

  task automatic put(input logic [31:0] i, input logic [2:0] op, input logic [4:0] t);
    in_valid = 1'b1; instr = i; ext_op = op; in_tag = t;
    @(posedge clk); #1;
  endtask

  // Single op through an unstalled pipe; literal result one cycle later.
  task automatic lit(input string name, input logic [31:0] i, input logic [2:0] op,
                     input logic [4:0] t, input logic [63:0] e32, input logic [63:0] e64);
    chk({name, "_model32"}, ref_imm(i, op, 32), e32);
    chk({name, "_model64"}, ref_imm(i, op, 64), e64);
    out_ready = 1'b1;
    put(i, op, t);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_vld"}, out_valid32, 1'b1);
    chk({name, "_imm32"}, {32'b0, out_imm32}, e32);
    chk({name, "_imm64"}, out_imm64, e64);
    chk({name, "_tag"}, out_tag32, t);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_vld"}, {out_valid32, out_valid64}, 2'b00);
    chk({name, "_rdy"}, {in_ready32, in_ready64}, 2'b11);
    chk({name, "_imm32"}, {32'b0, out_imm32}, 64'h0);
    chk({name, "_imm64"}, out_imm64, 64'h0);
    chk({name, "_tag"}, {out_tag32, out_tag64}, 10'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;

    // Formats, unstalled.
    lit("I",     32'hFFF00093, 3'b010, 5'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    lit("S",     32'hFE20AE23, 3'b001, 5'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    lit("B",     32'hFE000CE3, 3'b011, 5'd3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    lit("U",     32'h123450B7, 3'b100, 5'd4, 64'h1234_5000, 64'h1234_5000);
    lit("Uneg",  32'h800000B7, 3'b100, 5'd5, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    lit("J",     32'h0010006F, 3'b101, 5'd6, 64'h0000_0800, 64'h0000_0800);
    lit("SH",    32'h41F0D093, 3'b110, 5'd7, 64'h1F, 64'h1F);
    lit("SH6",   32'h43F0D093, 3'b110, 5'd8, 64'h1F, 64'h3F);
    lit("ZIMM",  32'hFFFFFFFF, 3'b111, 5'd9, 64'h1F, 64'h1F);
    lit("NONE",  32'hFFFFFFFF, 3'b000, 5'd10, 64'h0, 64'h0);

    // Back-to-back at full rate.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) put(32'h00100093 + (k << 20), 3'b010, 5'(16 + k));
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Backpressure: A in main, B in skid, C held at the input.
    out_ready = 1'b0;
    put(32'h00A00093, 3'b010, 5'h0A);
    put(32'h00B00093, 3'b010, 5'h0B);
    in_valid = 1'b1; instr = 32'h00C00093; ext_op = 3'b010; in_tag = 5'h0C;
    @(negedge clk);
    chk("bp_full_rdy", in_ready32, 1'b0);
    chk("bp_full_tag", out_tag32, 5'h0A);
    @(posedge clk); #1;
    chk("bp_hold_tag", out_tag32, 5'h0A);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_A", out_tag32, 5'h0A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_B", out_tag32, 5'h0B);
    chk("bp_B_rdy", in_ready32, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_C", out_tag32, 5'h0C);
    chk("bp_C_imm", {32'b0, out_imm32}, 64'hC);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drain", out_valid32, 1'b0);
    @(posedge clk); #1;

    // Flush with both entries full; offered input is dropped.
    out_ready = 1'b0;
    put(32'h00D00093, 3'b010, 5'h0D);
    put(32'h00E00093, 3'b010, 5'h0E);
    in_valid = 1'b1; instr = 32'h00F00093; in_tag = 5'h0F; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_full_vld", out_valid32, 1'b0);
    chk("fl_full_rdy", in_ready32, 1'b1);

    // Flush while in_ready=1: the flush-cycle input must still vanish.
    put(32'h01100093, 3'b010, 5'h11);
    in_valid = 1'b1; instr = 32'h01200093; in_tag = 5'h12; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_drop_vld", out_valid32, 1'b0);
      @(posedge clk); #1;
    end

    // Reset mid-stream with both entries full.
    out_ready = 1'b0;
    put(32'hFFF00093, 3'b010, 5'h13);
    put(32'hFFF00093, 3'b010, 5'h14);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst_mid");
    out_ready = 1'b1;
    put(32'h7FF00093, 3'b010, 5'h15);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", out_valid32, 1'b1);
    chk("post_rst_imm", {32'b0, out_imm32}, 64'h7FF);
    chk("post_rst_tag", out_tag32, 5'h15);
    @(posedge clk); #1;

    // Mixed traffic with irregular backpressure, checked by the model.
    for (int k = 0; k < 80; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = $urandom;
      ext_op    = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom_range(0, 31));
      flush     = (k == 50);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
